// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the WAIT_BUSY timeout used before a character is re-sent.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Cycles spent in WAIT_BUSY without tx_active before the character is re-issued.
    localparam int unsigned BUSY_TIMEOUT = 4;
    localparam int          TIMER_W      = 3;

endpackage

// File: rtl/uart_tx_arb_rr.sv
// Round-robin selector: returns the one-hot winner among the requests,
// searching upward from the pointer and wrapping at N-1 -> 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     win
);

    localparam int SW = PTR_W + 1;

    logic [SW-1:0]    sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates N character sources onto one UART transmitter.
// Optional packet locking is enabled with the macro UART_TX_ARB_LOCK_EN.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic [N-1:0]       grant,
    output logic [WIDTH-1:0]   tx_data,
    output logic               tx_send,
    input  logic               tx_active,
    input  logic               tx_sent,
    output logic               busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int SW    = PTR_W + 1;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [TIMER_W-1:0] timer;
    logic [N-1:0]       req_eligible;
    logic [N-1:0]       win;
    logic [PTR_W-1:0]   win_idx;
    logic [WIDTH-1:0]   sel_data;

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] i);
        logic [SW-1:0] s;
        s = {1'b0, i} + SW'(1);
        if (s >= SW'(N)) begin
            s = '0;
        end
        return s[PTR_W-1:0];
    endfunction

`ifdef UART_TX_ARB_LOCK_EN
    logic             locked;
    logic             cur_last;
    logic [PTR_W-1:0] owner_idx;

    // While a packet is open only its owner may compete.
    assign req_eligible = locked ? (req_valid & grant) : req_valid;
`else
    logic unused_last;

    assign unused_last  = ^req_last;
    assign req_eligible = req_valid;
`endif

    rr_arbiter #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (req_eligible),
        .ptr (ptr),
        .win (win)
    );

    always_comb begin
        win_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win[i]) begin
                win_idx  = PTR_W'(i);
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The acceptance pulse coincides with the edge that latches the character.
    assign req_ready = (rst_n && (state == IDLE)) ? win : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            tx_data <= '0;
            tx_send <= 1'b0;
            ptr     <= '0;
            timer   <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            locked    <= 1'b0;
            cur_last  <= 1'b0;
            owner_idx <= '0;
`endif
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_eligible) begin
                        grant   <= win;
                        tx_data <= sel_data;
                        tx_send <= 1'b1;
                        timer   <= '0;
                        state   <= ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                        cur_last  <= |(req_last & win);
                        owner_idx <= win_idx;
`else
                        ptr <= ptr_after(win_idx);
`endif
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_active) begin
                        state <= WAIT_DONE;
                    end else if (timer == TIMER_W'(BUSY_TIMEOUT - 1)) begin
                        tx_send <= 1'b1;
                        state   <= ISSUE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_sent || !tx_active) begin
                        state <= IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                        if (cur_last) begin
                            grant  <= '0;
                            locked <= 1'b0;
                            ptr    <= ptr_after(owner_idx);
                        end else begin
                            locked <= 1'b1;
                        end
`else
                        grant <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb with a behavioural UART transmitter;
// the packet-lock scenario is compiled only when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [W-1:0]   tx_data;
    logic           tx_send;
    logic           tx_active;
    logic           tx_sent;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arb #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_send   (tx_send),
        .tx_active (tx_active),
        .tx_sent   (tx_sent),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    int         cyc = 0;
    logic [W-1:0] send_data[$];
    int         send_cyc[$];
    int         ready_cnt[N];
    int         multi_ready = 0;
    int         multi_grant = 0;
    bit         tx_en = 1'b1;
    int         tcnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sent_at(input int i);
        if (i < send_data.size()) return 32'(send_data[i]);
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] gap_at(input int i);
        if (i + 1 < send_cyc.size()) return 32'(send_cyc[i+1] - send_cyc[i]);
        return 32'hDEAD;
    endfunction

    task automatic clear_log();
        send_data.delete();
        send_cyc.delete();
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        multi_ready = 0;
        multi_grant = 0;
    endtask

    // Observe DUT outputs on the falling edge, away from the active edge.
    initial begin
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tx_send === 1'b1) begin
                send_data.push_back(tx_data);
                send_cyc.push_back(cyc);
            end
            for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) ready_cnt[i]++;
            if ($countones(req_ready) > 1) multi_ready++;
            if ($countones(grant) > 1) multi_grant++;
        end
    end

    // Transmitter model: busy for several cycles after a start pulse, then end pulse.
    initial begin
        tx_active = 1'b0;
        tx_sent   = 1'b0;
        tcnt      = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_sent = 1'b0;
            if (tx_en && tx_send && !tx_active) begin
                tx_active = 1'b1;
                tcnt      = 3;
            end else if (tx_active) begin
                if (tcnt == 0) begin
                    tx_active = 1'b0;
                    tx_sent   = 1'b1;
                end else begin
                    tcnt--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic accept(input int idx, input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (req_ready[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check(tag, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sends(input int n, input string tag);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (send_data.size() >= n) break;
        end
        check(tag, 32'(send_data.size() >= n), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_last  = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant",   32'(grant),     32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_tx_send", 32'(tx_send),   32'h0);
        check("rst_tx_data", 32'(tx_data),   32'h0);
        check("rst_ready",   32'(req_ready), 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // Single requester
        clear_log();
        req_data[7:0] = 8'h55;
        req_valid     = 4'b0001;
        accept(0, "single_accept");
        req_valid = '0;
        check("single_send",   32'(tx_send), 32'h1);
        check("single_data",   32'(tx_data), 32'h55);
        check("single_grant",  32'(grant),   32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("single_hold_grant", 32'(grant),   32'h1);
        check("single_hold_data",  32'(tx_data), 32'h55);
        check("single_hold_send",  32'(tx_send), 32'h0);
        wait_idle("single_idle");
        check("single_grant_clr", 32'(grant),            32'h0);
        check("single_nsend",     32'(send_data.size()), 32'd1);
        check("single_nready",    32'(ready_cnt[0]),     32'd1);
        check("single_logdata",   sent_at(0),            32'h55);

        // Contention: all four requesters held valid
        do_reset();
        clear_log();
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b1111;
        wait_sends(5, "cont_progress");
        req_valid = '0;
        wait_idle("cont_idle");
        check("cont_nsend", 32'(send_data.size()), 32'd5);
        check("cont_0", sent_at(0), 32'hA0);
        check("cont_1", sent_at(1), 32'hA1);
        check("cont_2", sent_at(2), 32'hA2);
        check("cont_3", sent_at(3), 32'hA3);
        check("cont_4", sent_at(4), 32'hA0);
        check("cont_onehot_grant", 32'(multi_grant),  32'd0);
        check("cont_onehot_ready", 32'(multi_ready),  32'd0);
        check("cont_ready0",       32'(ready_cnt[0]), 32'd2);

        // Wrap-around: requester 3 served, then 0 wins over 3
        do_reset();
        req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req_valid = 4'b1000;
        accept(3, "wrap_first");
        req_valid = '0;
        wait_idle("wrap_idle1");
        clear_log();
        req_valid = 4'b1001;
        wait_sends(2, "wrap_progress");
        req_valid = '0;
        wait_idle("wrap_idle2");
        check("wrap_0", sent_at(0), 32'hD0);
        check("wrap_1", sent_at(1), 32'hD3);

        // Timeout: transmitter never goes active
        do_reset();
        tx_en = 1'b0;
        clear_log();
        req_data[23:16] = 8'h3C;
        req_valid       = 4'b0100;
        accept(2, "to_accept");
        req_valid = '0;
        wait_sends(3, "to_progress");
        check("to_gap0",  gap_at(0),             32'd5);
        check("to_gap1",  gap_at(1),             32'd5);
        check("to_data1", sent_at(1),            32'h3C);
        check("to_data2", sent_at(2),            32'h3C);
        check("to_ready", 32'(ready_cnt[2]),     32'd1);
        check("to_grant", 32'(grant),            32'h4);
        check("to_busy",  32'(busy),             32'h1);
        do_reset();
        tx_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset while in WAIT_DONE
        req_data[15:8] = 8'h77;
        req_valid      = 4'b0010;
        accept(1, "rst_wd_accept");
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_wd_pre_busy",   32'(busy),      32'h1);
        check("rst_wd_pre_active", 32'(tx_active), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wd_grant", 32'(grant),   32'h0);
        check("rst_wd_busy",  32'(busy),    32'h0);
        check("rst_wd_send",  32'(tx_send), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check("rst_wd_nosend", 32'(send_data.size()), 32'd0);
        repeat (8) @(posedge clk);
        #1;

`ifdef UART_TX_ARB_LOCK_EN
        // Packet lock: requester 1 sends three characters before requester 2
        do_reset();
        clear_log();
        req_data        = '0;
        req_data[15:8]  = 8'h11;
        req_data[23:16] = 8'h22;
        req_last        = 4'b0100;
        req_valid       = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            accept(1, "lock_accept");
            if (k < 2) begin
                req_data[15:8] = 8'h12 + 8'(k);
                req_last[1]    = (k == 1);
            end else begin
                req_valid[1] = 1'b0;
            end
        end
        wait_sends(4, "lock_progress");
        req_valid = '0;
        wait_idle("lock_idle");
        check("lock_0", sent_at(0), 32'h11);
        check("lock_1", sent_at(1), 32'h12);
        check("lock_2", sent_at(2), 32'h13);
        check("lock_3", sent_at(3), 32'h22);
        req_last = '1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
